// File: rtl/msp430_trace_term_monitor.sv
// Per-core trace consumer: R3 shadow, PUTC/EXIT marker decode, character FIFO,
// retired-instruction counter, idle timeout and the all-cores done reduction.
module msp430_trace_term_monitor #(
  parameter int              DATA_W         = 16,
  parameter int              PC_W           = 16,
  parameter int              INSN_W         = 16,
  parameter logic [INSN_W-1:0] EXIT_INSN    = 16'h4303,
  parameter logic [INSN_W-1:0] PUTC_INSN    = 16'h4313,
  parameter int              FIFO_DEPTH     = 8,
  parameter int              TIMEOUT_CYCLES = 100000,
  parameter int              TERM_CROSS_NUM = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trace_valid,
  input  logic [PC_W-1:0]           trace_pc,
  input  logic [INSN_W-1:0]         trace_insn,
  input  logic                      trace_wben,
  input  logic [3:0]                trace_wbreg,
  input  logic [DATA_W-1:0]         trace_wbdata,
  input  logic [TERM_CROSS_NUM-1:0] termination_all_i,
  output logic                      termination_o,
  output logic [DATA_W-1:0]         exit_code_o,
  output logic                      char_valid_o,
  output logic [7:0]                char_data_o,
  input  logic                      char_ready_i,
  output logic                      overflow_o,
  output logic [31:0]               insn_count_o,
  output logic                      timeout_o,
  output logic                      all_done_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   TO_LIM  = 32'(TIMEOUT_CYCLES);

  logic [DATA_W-1:0] r3_shadow;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       idle_cnt;

  logic is_exit, push_req, pop, push, drop, fifo_full;

  // The PC is carried by the trace but no marker depends on it.
  logic unused_pc;
  assign unused_pc = ^trace_pc;

  assign is_exit   = trace_valid && (trace_insn == EXIT_INSN) && !termination_o;
  assign push_req  = trace_valid && (trace_insn == PUTC_INSN) && !termination_o;
  assign fifo_full = (count == DEPTH_C);

  // Character port handshake: a character transfers on every rising edge where
  // char_valid_o and char_ready_i are both high; char_data_o is stable while
  // char_valid_o is high and not yet accepted.
  assign char_valid_o = (count != '0);
  assign char_data_o  = mem[rd_ptr];
  assign pop          = char_valid_o && char_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push         = push_req && (!fifo_full || pop);
  assign drop         = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_shadow     <= '0;
      termination_o <= 1'b0;
      exit_code_o   <= '0;
    end else begin
      if (trace_valid && trace_wben && (trace_wbreg == 4'd3))
        r3_shadow <= trace_wbdata;
      // Markers see the shadow value from before this cycle's write-back.
      if (is_exit) begin
        termination_o <= 1'b1;
        exit_code_o   <= r3_shadow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= r3_shadow[7:0];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn_count_o <= '0;
    end else if (trace_valid && !termination_o && (insn_count_o != 32'hFFFF_FFFF)) begin
      insn_count_o <= insn_count_o + 32'd1;
    end
  end

  // Idle counter saturates at the limit; a zero limit keeps it and the flag at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else if (TO_LIM != 32'd0) begin
      if (trace_valid)             idle_cnt <= '0;
      else if (idle_cnt != TO_LIM) idle_cnt <= idle_cnt + 32'd1;
      if ((idle_cnt == TO_LIM) && !termination_o) timeout_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_done_o <= 1'b0;
    else        all_done_o <= &termination_all_i;
  end

endmodule

// File: tb/tb_msp430_trace_term_monitor.sv
// Directed bench for msp430_trace_term_monitor: markers, character FIFO,
// counters, timeout and all-done, with an expected-character queue.
module tb_msp430_trace_term_monitor;

  localparam logic [15:0] EXIT_OP = 16'h4303;
  localparam logic [15:0] PUTC_OP = 16'h4313;
  localparam logic [15:0] NOP_OP  = 16'h1234;
  localparam logic [15:0] MOV_OP  = 16'h4034;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_valid = 1'b0;
  logic [15:0] trace_pc = '0;
  logic [15:0] trace_insn = '0;
  logic        trace_wben = 1'b0;
  logic [3:0]  trace_wbreg = '0;
  logic [15:0] trace_wbdata = '0;
  logic [7:0]  termination_all_i = '0;
  logic        char_ready_i = 1'b0;
  logic        termination_o;
  logic [15:0] exit_code_o;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic        overflow_o;
  logic [31:0] insn_count_o;
  logic        timeout_o;
  logic        all_done_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [31:0] exp_cnt = 0;
  logic        m_term = 1'b0;

  msp430_trace_term_monitor #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_insn(trace_insn), .trace_wben(trace_wben), .trace_wbreg(trace_wbreg),
    .trace_wbdata(trace_wbdata), .termination_all_i(termination_all_i),
    .termination_o(termination_o), .exit_code_o(exit_code_o),
    .char_valid_o(char_valid_o), .char_data_o(char_data_o),
    .char_ready_i(char_ready_i), .overflow_o(overflow_o),
    .insn_count_o(insn_count_o), .timeout_o(timeout_o), .all_done_o(all_done_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted character must match the queue head
  always @(negedge clk) begin
    if (rst_n && char_valid_o && char_ready_i) begin
      if (exp_q.size() == 0) check("char_extra", 32'(exp_q.size()), 32'd1);
      else check("char_data", 32'(char_data_o), 32'(exp_q.pop_front()));
    end
  end

  // driver: apply one cycle of trace, consume it at the next edge, return #1 after
  task automatic drive(input logic v, input logic [15:0] insn, input logic wben,
                       input logic [15:0] data);
    trace_valid  = v;
    trace_insn   = insn;
    trace_wben   = wben;
    trace_wbreg  = wben ? 4'd3 : 4'd0;
    trace_wbdata = data;
    trace_pc     = trace_pc + 16'd2;
    if (rst_n && v && !m_term) begin
      exp_cnt = exp_cnt + 1;
      if (insn == EXIT_OP) m_term = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_r3(input logic [15:0] d); drive(1'b1, MOV_OP, 1'b1, d); endtask
  task automatic putc();                       drive(1'b1, PUTC_OP, 1'b0, 16'h0); endtask
  task automatic nop();                        drive(1'b1, NOP_OP, 1'b0, 16'h0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, NOP_OP, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    m_term  = 1'b0;
    check("rst_char_valid", 32'(char_valid_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_term", 32'(termination_o), 32'd0);
    check("rst_count", insn_count_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset held while the trace toggles
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive(i[0], PUTC_OP, 1'b1, 16'h00FF);
    check("rst_term", 32'(termination_o), 32'd0);
    check("rst_exit_code", 32'(exit_code_o), 32'd0);
    check("rst_char_valid", 32'(char_valid_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_count", insn_count_o, 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_all_done", 32'(all_done_o), 32'd0);
    rst_n = 1'b1;
    nop();
    nop();
    check("post_rst_term", 32'(termination_o), 32'd0);
    check("post_rst_char", 32'(char_valid_o), 32'd0);
    check("post_rst_count", insn_count_o, exp_cnt);

    // PUTC with a ready consumer
    char_ready_i = 1'b1;
    wr_r3(16'h0048);
    putc();
    exp_q.push_back(8'h48);
    check("putc_latency", 32'(char_valid_o), 32'd1);
    wr_r3(16'h0069);
    check("putc_popped", 32'(char_valid_o), 32'd0);
    putc();
    exp_q.push_back(8'h69);
    check("putc2_valid", 32'(char_valid_o), 32'd1);
    nop();
    check("putc_empty", 32'(char_valid_o), 32'd0);

    // overflow with a stalled consumer
    char_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_r3(16'h0030 + 16'(i));
      putc();
      if (i < 8) exp_q.push_back(8'h30 + 8'(i));
      if (i == 7) check("ovf_before", 32'(overflow_o), 32'd0);
    end
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_valid", 32'(char_valid_o), 32'd1);
    // full FIFO, pop and push in the same cycle
    wr_r3(16'h0041);
    char_ready_i = 1'b1;
    putc();
    exp_q.push_back(8'h41);
    char_ready_i = 1'b0;
    nop();
    check("full_head", 32'(char_data_o), 32'h31);
    char_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) nop();
    check("drain_empty", 32'(char_valid_o), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    check("count_mid", insn_count_o, exp_cnt);

    // idle timeout on a running core
    idle(10);
    check("timeout_early", 32'(timeout_o), 32'd0);
    idle(10);
    check("timeout_set", 32'(timeout_o), 32'd1);
    check("count_idle", insn_count_o, exp_cnt);

    // mid-operation reset discards a queued character and sticky flags
    char_ready_i = 1'b0;
    wr_r3(16'h005A);
    putc();
    check("queued_before_rst", 32'(char_valid_o), 32'd1);
    do_reset();

    // EXIT with a same-cycle R3 write uses the old shadow
    wr_r3(16'h0055);
    drive(1'b1, EXIT_OP, 1'b1, 16'h002A);
    check("exit_term", 32'(termination_o), 32'd1);
    check("exit_nobypass", 32'(exit_code_o), 32'h0055);
    check("exit_count", insn_count_o, exp_cnt);
    do_reset();

    // EXIT with code 0, then markers are ignored
    wr_r3(16'h0077);
    wr_r3(16'h0000);
    drive(1'b1, EXIT_OP, 1'b0, 16'h0);
    check("exit0_term", 32'(termination_o), 32'd1);
    check("exit0_code", 32'(exit_code_o), 32'h0000);
    check("exit0_count", insn_count_o, 32'd3);
    char_ready_i = 1'b1;
    wr_r3(16'h0041);
    putc();
    check("putc_ignored", 32'(char_valid_o), 32'd0);
    wr_r3(16'h0099);
    drive(1'b1, EXIT_OP, 1'b0, 16'h0);
    check("exit_ignored", 32'(exit_code_o), 32'h0000);
    check("count_frozen", insn_count_o, exp_cnt);
    idle(20);
    check("timeout_term", 32'(timeout_o), 32'd0);
    check("term_hold", 32'(termination_o), 32'd1);

    // all-done reduction
    termination_all_i = 8'h7F;
    nop();
    check("alldone_7f", 32'(all_done_o), 32'd0);
    termination_all_i = 8'hFF;
    check("alldone_lat", 32'(all_done_o), 32'd0);
    nop();
    check("alldone_ff", 32'(all_done_o), 32'd1);
    termination_all_i = 8'h7F;
    nop();
    check("alldone_drop", 32'(all_done_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
